// File: rtl/toggle_event_receiver.sv
// toggle_event_receiver: multi-channel toggle-synchronizer receiver with saturating pending-event counters; define TOGGLE_RX_STICKY_OVF_EN for sticky ovf
module toggle_event_receiver #(
    parameter int CHANNELS    = 4,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 3
) (
    input  logic                      clk2,
    input  logic                      reset,
    input  logic [CHANNELS-1:0]       tog_in,
    output logic [CHANNELS-1:0]       pulse_out,
    output logic [CHANNELS-1:0]       evt_valid,
    input  logic [CHANNELS-1:0]       evt_ready,
    output logic [CHANNELS*CNT_W-1:0] pend_cnt,
    output logic [CHANNELS-1:0]       ovf,
    input  logic [CHANNELS-1:0]       ovf_clr
);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync;
        logic                   prev, det, dec, full, drop, pulse, ovf_r;
        logic [CNT_W-1:0]       cnt, cnt_nx;

        // toggle detection and counter next state; a detection plus a consume leaves the count alone
        always_comb begin
            det    = sync[SYNC_STAGES-1] ^ prev;
            dec    = (cnt != '0) & evt_ready[i];
            full   = cnt == CNT_MAX;
            drop   = det & ~dec & full;
            cnt_nx = (det & ~dec & ~full) ? cnt + 1'b1 : (~det & dec) ? cnt - 1'b1 : cnt;
        end

        // synchronizer chain, edge history, pulse, counter and overflow registers
        always_ff @(posedge clk2) begin
            if (reset) begin
                sync  <= '0;
                prev  <= 1'b0;
                pulse <= 1'b0;
                cnt   <= '0;
                ovf_r <= 1'b0;
            end else begin
                sync  <= {sync[SYNC_STAGES-2:0], tog_in[i]};
                prev  <= sync[SYNC_STAGES-1];
                pulse <= det;
                cnt   <= cnt_nx;
`ifdef TOGGLE_RX_STICKY_OVF_EN
                ovf_r <= drop | (ovf_r & ~ovf_clr[i]);
`else
                ovf_r <= drop;
`endif
            end
        end

        assign pulse_out[i]               = pulse;
        assign evt_valid[i]               = cnt != '0;
        assign pend_cnt[i*CNT_W +: CNT_W] = cnt;
        assign ovf[i]                     = ovf_r;
    end

`ifndef TOGGLE_RX_STICKY_OVF_EN
    logic unused_clr;
    assign unused_clr = ^ovf_clr;
`endif
endmodule

// File: tb/tb_toggle_event_receiver.sv
// tb_toggle_event_receiver: randomized scoreboard bench for toggle_event_receiver against an event-level model
module tb_toggle_event_receiver;
    localparam int CH   = 4;
    localparam int SS   = 2;
    localparam int CW   = 3;
    localparam int MAXC = (1 << CW) - 1;

    logic             clk2 = 1'b0;
    logic             reset;
    logic [CH-1:0]    tog_in, pulse_out, evt_valid, evt_ready, ovf, ovf_clr;
    logic [CH*CW-1:0] pend_cnt;

    toggle_event_receiver #(.CHANNELS(CH), .SYNC_STAGES(SS), .CNT_W(CW)) dut (
        .clk2(clk2), .reset(reset), .tog_in(tog_in), .pulse_out(pulse_out),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .pend_cnt(pend_cnt),
        .ovf(ovf), .ovf_clr(ovf_clr)
    );

    initial forever #5 clk2 = ~clk2;

    typedef struct {int ch; int at;} ev_t;
    ev_t           arr_q[$];
    ev_t           exp_q[$];
    int            cyc = 0;
    int            checks = 0;
    int            errors = 0;
    int            mcnt[CH];
    logic [CH-1:0] movf;
    int            last[CH];

    task automatic chk(input string name, input int c, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s ch%0d cycle %0d: got %0d expected %0d", name, c, cyc, act, exp);
        end
    endtask

    // event-level model: each toggle arrives at a known edge and is counted, consumed or dropped
    task automatic model_step();
        logic [CH-1:0] arrived;
        bit cons, drop;
        cyc++;
        if (reset) begin
            arr_q.delete();
            exp_q.delete();
            foreach (mcnt[c]) mcnt[c] = 0;
            movf = '0;
        end else begin
            arrived = '0;
            while (arr_q.size() > 0 && arr_q[0].at == cyc) begin
                arrived[arr_q[0].ch] = 1'b1;
                void'(arr_q.pop_front());
            end
            for (int c = 0; c < CH; c++) begin
                cons = mcnt[c] > 0 && evt_ready[c];
                drop = 0;
                if (arrived[c] && !cons) begin
                    if (mcnt[c] == MAXC) drop = 1;
                    else mcnt[c]++;
                end else if (!arrived[c] && cons) mcnt[c]--;
`ifdef TOGGLE_RX_STICKY_OVF_EN
                movf[c] = drop | (movf[c] & !ovf_clr[c]);
`else
                movf[c] = drop;
`endif
            end
        end
    endtask

    initial forever begin
        @(posedge clk2);
        model_step();
    end

    // monitor: pops expected pulses due this edge and compares all outputs
    initial forever begin
        logic [CH-1:0] exp_p;
        @(negedge clk2);
        if (cyc > 0) begin
            exp_p = '0;
            while (exp_q.size() > 0 && exp_q[0].at <= cyc) begin
                exp_p[exp_q[0].ch] = 1'b1;
                void'(exp_q.pop_front());
            end
            chk("pulse_mask", -1, int'(pulse_out), int'(exp_p));
            for (int c = 0; c < CH; c++) begin
                chk("pend_cnt", c, int'(pend_cnt[c*CW +: CW]), mcnt[c]);
                chk("evt_valid", c, int'(evt_valid[c]), int'(mcnt[c] != 0));
                chk("ovf", c, int'(ovf[c]), int'(movf[c]));
            end
        end
    end

    function automatic logic [CH-1:0] rnd(input int p);
        logic [CH-1:0] v;
        for (int i = 0; i < CH; i++) v[i] = int'($urandom_range(99)) < p;
        return v;
    endfunction

    task automatic drive(input logic [CH-1:0] r, input logic [CH-1:0] t, input logic [CH-1:0] c, input logic rs);
        ev_t e;
        @(posedge clk2);
        #1;
        evt_ready = r;
        ovf_clr   = c;
        reset     = rs;
        if (rs) begin
            tog_in = '0;
            foreach (last[k]) last[k] = cyc;
        end else begin
            for (int k = 0; k < CH; k++) begin
                if (t[k] && cyc >= last[k] + 2) begin
                    tog_in[k] = ~tog_in[k];
                    last[k]   = cyc;
                    e.ch = k;
                    e.at = cyc + 1 + SS;
                    arr_q.push_back(e);
                    exp_q.push_back(e);
                end
            end
        end
    endtask

    initial begin
        reset = 1'b1; tog_in = '0; evt_ready = '0; ovf_clr = '0;
        movf = '0;
        foreach (mcnt[c]) mcnt[c] = 0;
        foreach (last[c]) last[c] = -10;
        repeat (3) drive('0, '0, '0, 1'b1);
        drive('0, 4'b0001, '0, 1'b0);
        repeat (4) drive('0, '0, '0, 1'b0);
        drive(4'b0001, '0, '0, 1'b0);
        repeat (2) drive('0, '0, '0, 1'b0);
        repeat (60) drive('0, rnd(40), '0, 1'b0);
        repeat (10) drive('0, '0, '0, 1'b0);
        drive('0, '0, 4'hF, 1'b0);
        drive('0, 4'hF, '0, 1'b0);
        drive('0, '0, '0, 1'b0);
        drive(4'hF, '0, '0, 1'b0);
        repeat (2) drive('0, '0, '0, 1'b0);
        repeat (4) drive(4'hF, '0, '0, 1'b0);
        drive('0, 4'hF, '0, 1'b0);
        drive('0, '0, '0, 1'b0);
        drive(4'hF, '0, '0, 1'b0);
        repeat (2) drive('0, '0, '0, 1'b0);
        repeat (300) drive(rnd(40), rnd(35), rnd(5), 1'b0);
        repeat (40) drive('0, rnd(50), '0, 1'b0);
        drive('0, 4'hF, '0, 1'b0);
        drive('0, '0, '0, 1'b1);
        repeat (10) drive('0, '0, '0, 1'b0);
        drive('0, 4'hF, '0, 1'b0);
        repeat (4) drive('0, '0, '0, 1'b0);
        repeat (3) drive(4'b0100, '0, '0, 1'b0);
        repeat (3) drive('0, '0, '0, 1'b0);
        repeat (300) drive(rnd(60), rnd(30), rnd(10), $urandom_range(99) == 0);
        repeat (6) drive('0, '0, '0, 1'b0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
